cu_edge_cacheline_unpack: RTL and testbench

//  Sits between the CU read-response path and the edge job buffer (CU_EDGE_JOB_BUFFER_SIZE deep).

---
 rtl/cu_edge_cacheline_unpack.sv | 200 ++++++++++++++++++++
 tb/tb_cu_edge_cacheline_unpack.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_edge_cacheline_unpack.sv
// Purpose: splits one 1024-bit edge cacheline into 32-bit edges tagged with the source vertex (optional macro CU_UNPACK_SKID_EN adds a pending line slot).
// Latency: first edge is valid the cycle after line acceptance, then 1 edge/cycle while edge_out_ready is held high.
// Backpressure: edge_out_ready low freezes the edge outputs; line_in_ready is low while draining unless the pending slot is built in and empty.
module cu_edge_cacheline_unpack #(
  parameter int CACHELINE_SIZE_BITS = 1024,
  parameter int EDGE_SIZE_BITS      = 32,
  parameter int CACHELINE_EDGE_NUM  = 32,
  parameter int VERTEX_SIZE_BITS    = 32
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  enabled,
  input  logic                                  line_in_valid,
  output logic                                  line_in_ready,
  input  logic [CACHELINE_SIZE_BITS-1:0]        line_in_data,
  input  logic [$clog2(CACHELINE_EDGE_NUM)-1:0] line_in_start,
  input  logic [$clog2(CACHELINE_EDGE_NUM):0]   line_in_count,
  input  logic [VERTEX_SIZE_BITS-1:0]           line_in_src,
  output logic                                  edge_out_valid,
  input  logic                                  edge_out_ready,
  output logic [EDGE_SIZE_BITS-1:0]             edge_out_data,
  output logic [VERTEX_SIZE_BITS-1:0]           edge_out_src,
  output logic                                  edge_out_last,
  output logic                                  clip_error
);

  localparam int IDX_W = $clog2(CACHELINE_EDGE_NUM);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Active line being drained.
  state_t                         state_q, state_d;
  logic [CACHELINE_SIZE_BITS-1:0] line_q;
  logic [VERTEX_SIZE_BITS-1:0]    src_q;
  logic [IDX_W-1:0]               idx_q;
  logic [CNT_W-1:0]               rem_q;
  logic                           clip_q;

  // Load path into the active registers.
  logic                           ld_en;
  logic                           ld_go;
  logic [CACHELINE_SIZE_BITS-1:0] ld_line;
  logic [VERTEX_SIZE_BITS-1:0]    ld_src;
  logic [IDX_W-1:0]               ld_idx;
  logic [CNT_W-1:0]               ld_rem;

  // Incoming line: edges available from the start index and the clipped count.
  logic [CNT_W-1:0]               in_avail;
  logic [CNT_W-1:0]               in_eff;
  logic                           in_clip;

  logic                           line_xfer;
  logic                           edge_xfer;

`ifdef CU_UNPACK_SKID_EN
  // Pending slot: holds the next line while the active one drains.
  logic                           pend_vld_q;
  logic [CACHELINE_SIZE_BITS-1:0] pend_line_q;
  logic [VERTEX_SIZE_BITS-1:0]    pend_src_q;
  logic [IDX_W-1:0]               pend_idx_q;
  logic [CNT_W-1:0]               pend_rem_q;
  logic                           pend_wr;
  logic                           pend_rd;
`endif

  // Clip the requested count to the edges left between start and the end of the line.
  always_comb begin
    in_avail = CNT_W'(CACHELINE_EDGE_NUM) - {1'b0, line_in_start};
    in_clip  = (line_in_count > in_avail);
    in_eff   = in_clip ? in_avail : line_in_count;
  end

`ifdef CU_UNPACK_SKID_EN
  // A new line can be taken whenever the pending slot is free, in either state.
  assign line_in_ready  = enabled & ~pend_vld_q;
`else
  // Single line register: only accept when nothing is draining.
  assign line_in_ready  = enabled & (state_q == IDLE);
`endif

  assign edge_out_valid = enabled & (state_q == DRAIN);
  assign edge_out_data  = line_q[int'(idx_q) * EDGE_SIZE_BITS +: EDGE_SIZE_BITS];
  assign edge_out_src   = src_q;
  assign edge_out_last  = (state_q == DRAIN) & (rem_q == CNT_W'(1));
  assign clip_error     = clip_q;

  assign line_xfer      = line_in_valid & line_in_ready;
  assign edge_xfer      = edge_out_valid & edge_out_ready;

  // A load with zero edges consumes the line without entering DRAIN.
  assign ld_go          = ld_en & (ld_rem != '0);

  // Next state and selection of which line (input or pending) loads into the active registers.
  always_comb begin
    state_d = state_q;
    ld_en   = 1'b0;
    ld_line = line_in_data;
    ld_src  = line_in_src;
    ld_idx  = line_in_start;
    ld_rem  = in_eff;
`ifdef CU_UNPACK_SKID_EN
    pend_wr = 1'b0;
    pend_rd = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (line_xfer) begin
          ld_en = 1'b1;
        end
      end
      DRAIN: begin
        if (edge_xfer && edge_out_last) begin
          state_d = IDLE;
`ifdef CU_UNPACK_SKID_EN
          // Chain straight into the next line so its first edge follows with no bubble.
          if (pend_vld_q) begin
            ld_en   = 1'b1;
            pend_rd = 1'b1;
            ld_line = pend_line_q;
            ld_src  = pend_src_q;
            ld_idx  = pend_idx_q;
            ld_rem  = pend_rem_q;
          end else if (line_xfer) begin
            ld_en = 1'b1;
          end
`endif
        end
`ifdef CU_UNPACK_SKID_EN
        // Zero-count lines are consumed on accept and never occupy the slot.
        else if (line_xfer && (in_eff != '0)) begin
          pend_wr = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (ld_go) begin
      state_d = DRAIN;
    end
  end

  // Active line registers: load a new line, or step one edge on each transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      src_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_go) begin
        line_q <= ld_line;
        src_q  <= ld_src;
        idx_q  <= ld_idx;
        rem_q  <= ld_rem;
      end else if (edge_xfer) begin
        rem_q <= rem_q - 1'b1;
        // Hold the index on the final edge so it never steps past the line end.
        if (!edge_out_last) begin
          idx_q <= idx_q + 1'b1;
        end
      end
      if (line_xfer && in_clip) begin
        clip_q <= 1'b1;
      end
    end
  end

`ifdef CU_UNPACK_SKID_EN
  // Pending slot: filled while draining, emptied when the active line finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_vld_q  <= 1'b0;
      pend_line_q <= '0;
      pend_src_q  <= '0;
      pend_idx_q  <= '0;
      pend_rem_q  <= '0;
    end else begin
      if (pend_wr) begin
        pend_vld_q  <= 1'b1;
        pend_line_q <= line_in_data;
        pend_src_q  <= line_in_src;
        pend_idx_q  <= line_in_start;
        pend_rem_q  <= in_eff;
      end else if (pend_rd) begin
        pend_vld_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cu_edge_cacheline_unpack.sv
// Purpose: self-checking bench for cu_edge_cacheline_unpack (build with CU_UNPACK_SKID_EN for the pending-slot variant).
// Latency: expects first edge one cycle after line acceptance.
// Backpressure: exercises random edge_out_ready stalls, enable pauses and mid-line reset.
module tb_cu_edge_cacheline_unpack;

  logic          clock = 1'b0;
  logic          reset;
  logic          enabled;
  logic          line_in_valid;
  logic          line_in_ready;
  logic [1023:0] line_in_data;
  logic [4:0]    line_in_start;
  logic [5:0]    line_in_count;
  logic [31:0]   line_in_src;
  logic          edge_out_valid;
  logic          edge_out_ready;
  logic [31:0]   edge_out_data;
  logic [31:0]   edge_out_src;
  logic          edge_out_last;
  logic          clip_error;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] src;
    logic        last;
  } exp_t;

  typedef struct {
    logic [4:0]  st;
    logic [5:0]  cnt;
    logic [31:0] src;
    logic [31:0] base;
    int          exp_edges;
    logic        exp_clip;
  } vec_t;

  exp_t        exp_q[$];
  int          edge_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          rx_cnt = 0;
  int          cyc    = 0;
  exp_t        got_e;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [31:0] prev_src;
  logic        prev_last;
  vec_t        vecs[8];

  cu_edge_cacheline_unpack dut (
    .clock          (clock),
    .reset          (reset),
    .enabled        (enabled),
    .line_in_valid  (line_in_valid),
    .line_in_ready  (line_in_ready),
    .line_in_data   (line_in_data),
    .line_in_start  (line_in_start),
    .line_in_count  (line_in_count),
    .line_in_src    (line_in_src),
    .edge_out_valid (edge_out_valid),
    .edge_out_ready (edge_out_ready),
    .edge_out_data  (edge_out_data),
    .edge_out_src   (edge_out_src),
    .edge_out_last  (edge_out_last),
    .clip_error     (clip_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edge monitor: scoreboard pop on every transfer, plus hold-stable check while stalled.
  always @(negedge clock) begin
    if (!reset) begin
      if (prev_stall && enabled) begin
        checks++;
        if (!edge_out_valid || edge_out_data != prev_data || edge_out_src != prev_src ||
            edge_out_last != prev_last) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b d=0x%0h expected v=1 d=0x%0h",
                   edge_out_valid, edge_out_data, prev_data);
        end
      end
      if (edge_out_valid && edge_out_ready) begin
        rx_cnt++;
        edge_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_edge: got d=0x%0h last=%0b expected no edge", edge_out_data, edge_out_last);
        end else begin
          got_e = exp_q.pop_front();
          if (edge_out_data !== got_e.data || edge_out_src !== got_e.src || edge_out_last !== got_e.last) begin
            errors++;
            $display("FAIL edge: got d=0x%0h s=0x%0h l=%0b expected d=0x%0h s=0x%0h l=%0b",
                     edge_out_data, edge_out_src, edge_out_last, got_e.data, got_e.src, got_e.last);
          end
        end
      end
      prev_stall = edge_out_valid && !edge_out_ready;
      prev_data  = edge_out_data;
      prev_src   = edge_out_src;
      prev_last  = edge_out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Offer a line (edge i = base + i) and push its expected edges when it is accepted.
  task automatic send_line(input logic [4:0] st, input logic [5:0] cnt, input logic [31:0] src,
                           input logic [31:0] base);
    int n;
    int eff;
    line_in_start = st;
    line_in_count = cnt;
    line_in_src   = src;
    for (int i = 0; i < 32; i++) line_in_data[i*32 +: 32] = base + 32'(i);
    line_in_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!line_in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!line_in_ready) begin
      errors++;
      $display("FAIL line_accept_timeout: got ready=0 expected ready=1 within 200 cycles");
    end else begin
      eff = (int'(cnt) > 32 - int'(st)) ? 32 - int'(st) : int'(cnt);
      for (int k = 0; k < eff; k++) begin
        exp_q.push_back('{data: base + 32'(st) + 32'(k), src: src, last: (k == eff - 1)});
      end
    end
    @(posedge clock);
    #1 line_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clock);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d edges outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before 400us");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0;
    int n;
    int gap_exp;

    vecs[0] = '{st: 5'd29, cnt: 6'd3,  src: 32'h9,  base: 32'h1000, exp_edges: 3,  exp_clip: 1'b0};
    vecs[1] = '{st: 5'd5,  cnt: 6'd10, src: 32'hA,  base: 32'h2000, exp_edges: 10, exp_clip: 1'b0};
    vecs[2] = '{st: 5'd31, cnt: 6'd1,  src: 32'hB,  base: 32'h3000, exp_edges: 1,  exp_clip: 1'b0};
    vecs[3] = '{st: 5'd0,  cnt: 6'd0,  src: 32'hC,  base: 32'h4000, exp_edges: 0,  exp_clip: 1'b0};
    vecs[4] = '{st: 5'd12, cnt: 6'd20, src: 32'hD,  base: 32'h5000, exp_edges: 20, exp_clip: 1'b0};
    vecs[5] = '{st: 5'd30, cnt: 6'd5,  src: 32'hE,  base: 32'h6000, exp_edges: 2,  exp_clip: 1'b1};
    vecs[6] = '{st: 5'd10, cnt: 6'd22, src: 32'hF,  base: 32'h7000, exp_edges: 22, exp_clip: 1'b1};
    vecs[7] = '{st: 5'd16, cnt: 6'd32, src: 32'h10, base: 32'h8000, exp_edges: 16, exp_clip: 1'b1};

    reset          = 1'b1;
    enabled        = 1'b0;
    line_in_valid  = 1'b0;
    line_in_data   = '0;
    line_in_start  = '0;
    line_in_count  = '0;
    line_in_src    = '0;
    edge_out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_line_in_ready", 64'(line_in_ready), 64'd0);
    chk("rst_edge_out_valid", 64'(edge_out_valid), 64'd0);
    chk("rst_edge_out_data", 64'(edge_out_data), 64'd0);
    chk("rst_edge_out_src", 64'(edge_out_src), 64'd0);
    chk("rst_edge_out_last", 64'(edge_out_last), 64'd0);
    chk("rst_clip_error", 64'(clip_error), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    enabled = 1'b1;
    @(negedge clock);
    chk("post_rst_ready", 64'(line_in_ready), 64'd1);
    @(posedge clock);
    #1;

    // Full line: 32 back-to-back edges, first one the cycle after acceptance.
    rx0 = rx_cnt;
    send_line(5'd0, 6'd32, 32'd7, 32'd100);
    @(negedge clock);
    chk("full_first_valid", 64'(edge_out_valid), 64'd1);
    chk("full_first_data", 64'(edge_out_data), 64'd100);
    n = 1;
    repeat (31) begin
      @(negedge clock);
      if (edge_out_valid) n++;
    end
    chk("full_consecutive", 64'(n), 64'd32);
    @(negedge clock);
    chk("full_done_valid", 64'(edge_out_valid), 64'd0);
    wait_drain();
    chk("full_edges", 64'(rx_cnt - rx0), 64'd32);

    // Table of single lines with ready held high.
    for (int v = 0; v < 8; v++) begin
      rx0 = rx_cnt;
      send_line(vecs[v].st, vecs[v].cnt, vecs[v].src, vecs[v].base);
      wait_drain();
      chk($sformatf("vec%0d_edges", v), 64'(rx_cnt - rx0), 64'(vecs[v].exp_edges));
      chk($sformatf("vec%0d_clip", v), 64'(clip_error), 64'(vecs[v].exp_clip));
    end

    // Random backpressure on a 10-edge line.
    rx0 = rx_cnt;
    edge_out_ready = 1'b0;
    send_line(5'd3, 6'd10, 32'h33, 32'h300);
    repeat (3) @(posedge clock);
    #1;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clock);
      #1 edge_out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    edge_out_ready = 1'b1;
    wait_drain();
    chk("bp_edges", 64'(rx_cnt - rx0), 64'd10);

    // Zero-count line: consumed, no edges, ready again next cycle.
    rx0 = rx_cnt;
    send_line(5'd4, 6'd0, 32'h44, 32'h400);
    @(negedge clock);
    chk("zero_ready_next", 64'(line_in_ready), 64'd1);
    repeat (3) @(negedge clock);
    chk("zero_no_edges", 64'(rx_cnt - rx0), 64'd0);
    @(posedge clock);
    #1;

    // Pause after 4 of 8 edges, then resume with edge 5.
    rx0 = rx_cnt;
    send_line(5'd4, 6'd8, 32'h55, 32'h500);
    repeat (4) @(posedge clock);
    #1 enabled = 1'b0;
    n = 0;
    repeat (3) begin
      @(negedge clock);
      if (edge_out_valid) n++;
    end
    chk("pause_valid_low", 64'(n), 64'd0);
    chk("pause_edges_so_far", 64'(rx_cnt - rx0), 64'd4);
    @(posedge clock);
    #1 enabled = 1'b1;
    @(negedge clock);
    chk("resume_valid", 64'(edge_out_valid), 64'd1);
    chk("resume_data", 64'(edge_out_data), 64'h508);
    wait_drain();
    chk("pause_total_edges", 64'(rx_cnt - rx0), 64'd8);

    // Reset after 2 edges: rest of the line is discarded.
    rx0 = rx_cnt;
    send_line(5'd0, 6'd8, 32'h66, 32'h600);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (edge_out_valid || edge_out_last) n++;
    end
    chk("rst_mid_quiet", 64'(n), 64'd0);
    chk("rst_mid_edges", 64'(rx_cnt - rx0), 64'd2);
    chk("rst_mid_clip_clear", 64'(clip_error), 64'd0);
    @(posedge clock);
    #1;

    // Two back-to-back 4-edge lines.
`ifdef CU_UNPACK_SKID_EN
    gap_exp = 1;
`else
    gap_exp = 2;
`endif
    edge_cyc.delete();
    send_line(5'd0, 6'd4, 32'h77, 32'h700);
    send_line(5'd8, 6'd4, 32'h88, 32'h800);
    wait_drain();
    chk("b2b_edges", 64'(edge_cyc.size()), 64'd8);
    if (edge_cyc.size() == 8) begin
      chk("b2b_gap", 64'(edge_cyc[4] - edge_cyc[3]), 64'(gap_exp));
      chk("b2b_span", 64'(edge_cyc[7] - edge_cyc[0]), 64'(6 + gap_exp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
